// File: rtl/operand_loader_if.sv
// Byte-stream in / operand-set out bundle for the operand loader.
// master drives the byte stream and consumes operands; slave is the loader.
interface operand_loader_if;
  logic        clear;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        splitIn;
  logic        carrySel;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        carryIn;
  logic        split;
  logic        opValid;
  logic        opReady;

  modport master (
    output clear, byteIn, byteValid,
    output splitIn, carrySel, opReady,
    input  byteReady, opA, opB,
    input  carryIn, split, opValid
  );

  modport slave (
    input  clear, byteIn, byteValid,
    input  splitIn, carrySel, opReady,
    output byteReady, opA, opB,
    output carryIn, split, opValid
  );
endinterface

// File: rtl/operand_loader.sv
// Assembles two 16-bit adder operands from a byte stream and
// holds them, with split/carry flags, until downstream takes them.
module operand_loader #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               resetN,
  operand_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    LOAD_A0,
    LOAD_A1,
    LOAD_B0,
    LOAD_B1,
    PRESENT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        split_q;
  logic        carry_q;
  logic        ready;
  logic        xfer;

  assign ready = (state != PRESENT);
  assign xfer  = bus.byteValid & ready;

  assign bus.byteReady = ready;
  assign bus.opValid   = (state == PRESENT);
  assign bus.opA       = op_a;
  assign bus.opB       = op_b;
  assign bus.split     = split_q;
  assign bus.carryIn   = carry_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD_A0: if (xfer) state_nx = LOAD_A1;
      LOAD_A1: if (xfer) state_nx = LOAD_B0;
      LOAD_B0: if (xfer) state_nx = LOAD_B1;
      LOAD_B1: if (xfer) state_nx = PRESENT;
      PRESENT: if (bus.opReady) state_nx = LOAD_A0;
      default: state_nx = LOAD_A0;
    endcase
    if (bus.clear) state_nx = LOAD_A0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= LOAD_A0;
    else         state <= state_nx;
  end

  // First byte of each operand lands in the high half when MSB_FIRST
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      op_a    <= '0;
      op_b    <= '0;
      split_q <= 1'b0;
      carry_q <= 1'b0;
    end else if (bus.clear) begin
      op_a    <= '0;
      op_b    <= '0;
      split_q <= 1'b0;
      carry_q <= 1'b0;
    end else if (xfer) begin
      unique case (state)
        LOAD_A0: begin
          if (MSB_FIRST) op_a[15:8] <= bus.byteIn;
          else           op_a[7:0]  <= bus.byteIn;
          split_q <= bus.splitIn;
          carry_q <= bus.carrySel;
        end
        LOAD_A1: begin
          if (MSB_FIRST) op_a[7:0]  <= bus.byteIn;
          else           op_a[15:8] <= bus.byteIn;
        end
        LOAD_B0: begin
          if (MSB_FIRST) op_b[15:8] <= bus.byteIn;
          else           op_b[7:0]  <= bus.byteIn;
        end
        LOAD_B1: begin
          if (MSB_FIRST) op_b[7:0]  <= bus.byteIn;
          else           op_b[15:8] <= bus.byteIn;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: MSB-first and LSB-first
// instances share one stimulus stream.
module tb_operand_loader;

  logic clk;
  logic resetN;
  int   n_checks;
  int   n_fail;

  operand_loader_if bus ();
  operand_loader_if bus0 ();

  assign bus0.clear     = bus.clear;
  assign bus0.byteIn    = bus.byteIn;
  assign bus0.byteValid = bus.byteValid;
  assign bus0.splitIn   = bus.splitIn;
  assign bus0.carrySel  = bus.carrySel;
  assign bus0.opReady   = bus.opReady;

  operand_loader #(.MSB_FIRST(1'b1)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  operand_loader #(.MSB_FIRST(1'b0)) dut0 (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus0.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(
    input logic [7:0] b,
    input logic       s,
    input logic       c
  );
    bus.byteValid = 1'b1;
    bus.byteIn    = b;
    bus.splitIn   = s;
    bus.carrySel  = c;
    step();
    bus.byteValid = 1'b0;
    bus.byteIn    = 8'h00;
    bus.splitIn   = 1'b0;
    bus.carrySel  = 1'b0;
  endtask

  task automatic gap();
    bus.byteValid = 1'b0;
    bus.byteIn    = 8'h99;
    step();
  endtask

  logic [7:0]  seq [8];
  logic [15:0] exp_a [2];
  logic [15:0] exp_b [2];
  logic        exp_s [2];
  logic        exp_c [2];
  int          pulse_cyc [2];
  int          npulse;
  int          idx;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    resetN        = 1'b0;
    bus.clear     = 1'b0;
    bus.byteIn    = 8'h00;
    bus.byteValid = 1'b0;
    bus.splitIn   = 1'b0;
    bus.carrySel  = 1'b0;
    bus.opReady   = 1'b0;

    #3;
    chk("rst_opvalid", 32'(bus.opValid), 32'd0);
    chk("rst_ready", 32'(bus.byteReady), 32'd1);
    chk("rst_opa", 32'(bus.opA), 32'd0);
    chk("rst_opb", 32'(bus.opB), 32'd0);
    chk("rst_flags", {30'd0, bus.split, bus.carryIn}, 32'd0);
    #9 resetN = 1'b1;
    step();

    // basic load
    put(8'h12, 1'b1, 1'b1);
    put(8'h34, 1'b0, 1'b0);
    put(8'hAB, 1'b0, 1'b0);
    chk("basic_notyet", 32'(bus.opValid), 32'd0);
    put(8'hCD, 1'b0, 1'b0);
    chk("basic_opa", 32'(bus.opA), 32'h1234);
    chk("basic_opb", 32'(bus.opB), 32'hABCD);
    chk("basic_split", 32'(bus.split), 32'd1);
    chk("basic_carry", 32'(bus.carryIn), 32'd1);
    chk("basic_valid", 32'(bus.opValid), 32'd1);
    chk("basic_ready", 32'(bus.byteReady), 32'd0);
    chk("lsb_opa", 32'(bus0.opA), 32'h3412);
    chk("lsb_opb", 32'(bus0.opB), 32'hCDAB);

    for (int i = 0; i < 10; i++) begin
      bus.byteValid = 1'b1;
      bus.byteIn    = 8'hFF;
      bus.splitIn   = 1'b0;
      bus.carrySel  = 1'b0;
      step();
      chk("hold_ops", {bus.opA, bus.opB}, 32'h1234ABCD);
      chk("hold_flags", {29'd0, bus.opValid, bus.split, bus.carryIn}, 32'd7);
    end

    // handoff: no byte taken in the handoff cycle
    bus.opReady   = 1'b1;
    bus.byteIn    = 8'hEE;
    bus.byteValid = 1'b1;
    step();
    bus.opReady   = 1'b0;
    bus.byteValid = 1'b0;
    chk("ho1_valid", 32'(bus.opValid), 32'd0);
    chk("ho1_ready", 32'(bus.byteReady), 32'd1);
    chk("ho1_opa", 32'(bus.opA), 32'h1234);

    // gapped load
    put(8'h01, 1'b0, 1'b0);
    gap();
    put(8'h02, 1'b1, 1'b1);
    gap();
    put(8'h03, 1'b1, 1'b1);
    gap();
    chk("gap_3bytes", 32'(bus.opValid), 32'd0);
    chk("gap_partial", 32'(bus.opA), 32'h0102);
    put(8'h04, 1'b0, 1'b0);
    chk("gap_valid", 32'(bus.opValid), 32'd1);
    chk("gap_ops", {bus.opA, bus.opB}, 32'h01020304);
    chk("gap_flags", {30'd0, bus.split, bus.carryIn}, 32'd0);
    chk("gap_lsb", {bus0.opA, bus0.opB}, 32'h02010403);
    gap();
    chk("gap_hold", 32'(bus.opValid), 32'd1);

    bus.opReady = 1'b1;
    step();
    bus.opReady = 1'b0;
    chk("ho2_valid", 32'(bus.opValid), 32'd0);
    chk("ho2_ready", 32'(bus.byteReady), 32'd1);

    put(8'h5A, 1'b1, 1'b0);
    put(8'hA5, 1'b0, 1'b1);
    put(8'h0F, 1'b0, 1'b1);
    put(8'hF0, 1'b0, 1'b1);
    chk("set2_ops", {bus.opA, bus.opB}, 32'h5AA50FF0);
    chk("set2_flags", {30'd0, bus.split, bus.carryIn}, 32'd2);
    chk("set2_valid", 32'(bus.opValid), 32'd1);
    bus.opReady = 1'b1;
    step();
    bus.opReady = 1'b0;

    // clear mid-load
    put(8'h11, 1'b1, 1'b1);
    put(8'h22, 1'b0, 1'b0);
    chk("clr_pre", 32'(bus.opA), 32'h1122);
    bus.clear     = 1'b1;
    bus.byteValid = 1'b1;
    bus.byteIn    = 8'h55;
    step();
    bus.clear     = 1'b0;
    bus.byteValid = 1'b0;
    chk("clr_opa", 32'(bus.opA), 32'd0);
    chk("clr_opb", 32'(bus.opB), 32'd0);
    chk("clr_flags", {30'd0, bus.split, bus.carryIn}, 32'd0);
    chk("clr_ready", 32'(bus.byteReady), 32'd1);
    chk("clr_valid", 32'(bus.opValid), 32'd0);
    put(8'h66, 1'b0, 1'b1);
    put(8'h77, 1'b0, 1'b0);
    put(8'h88, 1'b0, 1'b0);
    chk("clr_3bytes", 32'(bus.opValid), 32'd0);
    put(8'h99, 1'b0, 1'b0);
    chk("clr_ops", {bus.opA, bus.opB}, 32'h66778899);
    chk("clr_flags2", {30'd0, bus.split, bus.carryIn}, 32'd1);
    chk("clr_valid2", 32'(bus.opValid), 32'd1);

    // asynchronous reset while presenting
    #2 resetN = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.opValid), 32'd0);
    chk("arst_ops", {bus.opA, bus.opB}, 32'd0);
    chk("arst_ready", 32'(bus.byteReady), 32'd1);
    chk("arst_carry", 32'(bus.carryIn), 32'd0);
    #2 resetN = 1'b1;
    step();
    chk("arst_after", 32'(bus.opValid), 32'd0);

    // back-to-back stream with opReady held high
    seq[0] = 8'hDE; seq[1] = 8'hAD;
    seq[2] = 8'hBE; seq[3] = 8'hEF;
    seq[4] = 8'h01; seq[5] = 8'h23;
    seq[6] = 8'h45; seq[7] = 8'h67;
    exp_a[0] = 16'hDEAD; exp_b[0] = 16'hBEEF;
    exp_a[1] = 16'h0123; exp_b[1] = 16'h4567;
    exp_s[0] = 1'b1; exp_c[0] = 1'b0;
    exp_s[1] = 1'b0; exp_c[1] = 1'b1;
    pulse_cyc[0] = 0;
    pulse_cyc[1] = 0;
    npulse = 0;
    idx    = 0;
    bus.opReady = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (bus.opValid) begin
        if (npulse < 2) begin
          chk("b2b_opa", 32'(bus.opA), 32'(exp_a[npulse]));
          chk("b2b_opb", 32'(bus.opB), 32'(exp_b[npulse]));
          chk("b2b_flags", {30'd0, bus.split, bus.carryIn},
              {30'd0, exp_s[npulse], exp_c[npulse]});
          pulse_cyc[npulse] = c;
        end
        npulse++;
      end
      bus.byteValid = (idx < 8);
      bus.byteIn    = (idx < 8) ? seq[idx] : 8'h00;
      bus.splitIn   = (idx == 0);
      bus.carrySel  = (idx == 4);
      if (bus.byteReady && idx < 8) idx++;
      step();
    end
    bus.byteValid = 1'b0;
    bus.opReady   = 1'b0;
    chk("b2b_pulses", 32'(npulse), 32'd2);
    chk("b2b_first", 32'(pulse_cyc[0]), 32'd4);
    chk("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
